// File: rtl/cpu_register_file.sv
// cpu_register_file: 32x32 MIPS register file with a per-register in-flight write scoreboard
//
// Purpose
//    Serves the decode stage's register-read port.
//    - Decode claims a destination register, which increments that register's pending counter.
//    - Writeback writes the register and releases it, which decrements the counter.
//    - reg_stall holds decode while a source register has an outstanding write, or while
//      the destination being claimed has a saturated counter.
//    - r0 always reads zero and is never tracked.
//
// Configuration
//    WB_BYPASS_EN (macro) : when defined, a writeback in the same cycle forwards its data to
//                           the matching source read. When it also releases the last
//                           in-flight write of that register, it clears busy() for that source.
//
// Parameters
//    PENDING_BITS : width of each per-register in-flight write counter
//
// Ports
//    clock          in   1   rising-edge clock
//    reset          in   1   synchronous reset, active-high
//    reg_read_valid in   1   reg_s/reg_t carry a real read this cycle
//    reg_s, reg_t   in   5   source register addresses
//    reg_id_valid   in   1   reg_id_d carries a destination claim this cycle
//    reg_id_d       in   5   destination register being claimed
//    reg_s_data     out  32  contents of reg_s (combinational)
//    reg_t_data     out  32  contents of reg_t (combinational)
//    reg_stall      out  1   decode must hold; no claim is taken (combinational)
//    wb_valid       in   1   writeback write strobe
//    wb_reg         in   5   writeback destination
//    wb_data        in   32  writeback value
//    idle           out  1   registered; every pending counter is zero
//    err_underflow  out  1   registered, sticky; a release hit a register with count 0
module cpu_register_file #(
   parameter int PENDING_BITS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        reg_read_valid,
   input  logic [4:0]  reg_s,
   input  logic [4:0]  reg_t,
   input  logic        reg_id_valid,
   input  logic [4:0]  reg_id_d,
   output logic [31:0] reg_s_data,
   output logic [31:0] reg_t_data,
   output logic        reg_stall,
   input  logic        wb_valid,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        idle,
   output logic        err_underflow
);

   logic [31:0]             regs_q [32];
   logic [31:0]             regs_d [32];
   logic [PENDING_BITS-1:0] pend_q [32];
   logic [PENDING_BITS-1:0] pend_d [32];
   logic                    idle_q, idle_d;
   logic                    err_q, err_d;
   logic                    fwd_s, fwd_t;
   logic                    busy_s, busy_t, full_d, claim;

`ifdef WB_BYPASS_EN
   assign fwd_s = wb_valid && wb_reg == reg_s && reg_s != 5'd0;
   assign fwd_t = wb_valid && wb_reg == reg_t && reg_t != 5'd0;
`else
   assign fwd_s = 1'b0;
   assign fwd_t = 1'b0;
`endif

   // A forwarded release of the only outstanding write makes the source ready this cycle;
   // with more writes still in flight the source stays busy.
   always_comb begin
      busy_s     = reg_s != 5'd0 && pend_q[reg_s] != '0 && !(fwd_s && pend_q[reg_s] == PENDING_BITS'(1));
      busy_t     = reg_t != 5'd0 && pend_q[reg_t] != '0 && !(fwd_t && pend_q[reg_t] == PENDING_BITS'(1));
      full_d     = reg_id_d != 5'd0 && pend_q[reg_id_d] == '1;
      reg_stall  = reset || (reg_read_valid && (busy_s || busy_t)) || (reg_id_valid && full_d);
      claim      = reg_id_valid && !reg_stall && reg_id_d != 5'd0;
      reg_s_data = (reset || reg_s == 5'd0) ? 32'd0 : fwd_s ? wb_data : regs_q[reg_s];
      reg_t_data = (reset || reg_t == 5'd0) ? 32'd0 : fwd_t ? wb_data : regs_q[reg_t];
   end

   // The release is applied before the claim, so a same-register claim and release leaves
   // the count unchanged. A release at count 0 still writes the data and flags the error.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      err_d  = err_q;
      idle_d = 1'b1;
      if (wb_valid && wb_reg != 5'd0) begin
         regs_d[wb_reg] = wb_data;
         if (pend_q[wb_reg] != '0) pend_d[wb_reg] = pend_q[wb_reg] - PENDING_BITS'(1);
         else err_d = 1'b1;
      end
      if (claim) pend_d[reg_id_d] = pend_d[reg_id_d] + PENDING_BITS'(1);
      for (int i = 0; i < 32; i++) idle_d = idle_d && pend_d[i] == '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         regs_q <= '{default: '0};
         pend_q <= '{default: '0};
         idle_q <= 1'b1;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
         idle_q <= idle_d;
         err_q  <= err_d;
      end
   end

   assign idle          = idle_q;
   assign err_underflow = err_q;

endmodule
